// File: rtl/sfu_acc_bank.sv
// Multi-address, multi-lane psum accumulator bank with saturation, optional ReLU
// on the final pass and valid/ready handshakes on both the psum and result sides.
module sfu_acc_bank #(
    parameter int psum_bw = 16,
    parameter int col     = 8,
    parameter int depth   = 16,
    parameter int addr_bw = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [col*psum_bw-1:0]   in_data,
    input  logic [addr_bw-1:0]       in_addr,
    input  logic                     in_first,
    input  logic                     in_last,
    input  logic                     relu_en,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [col*psum_bw-1:0]   out_data,
    output logic [addr_bw-1:0]       out_addr,
    output logic                     err
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    localparam logic signed [psum_bw-1:0] SAT_MAX = {1'b0, {(psum_bw-1){1'b1}}};
    localparam logic signed [psum_bw-1:0] SAT_MIN = {1'b1, {(psum_bw-1){1'b0}}};

    function automatic logic signed [psum_bw-1:0] sat_psum(input logic signed [psum_bw:0] v);
        if (v[psum_bw] != v[psum_bw-1])
            sat_psum = v[psum_bw] ? SAT_MIN : SAT_MAX;
        else
            sat_psum = v[psum_bw-1:0];
    endfunction

    function automatic logic signed [psum_bw-1:0] relu(input logic signed [psum_bw-1:0] v);
        relu = v[psum_bw-1] ? '0 : v;
    endfunction

    logic signed [psum_bw-1:0] acc [depth][col];
    logic [depth-1:0]          live_p1;
    logic                      err_p1;
    state_t                    state_p1;
    state_t                    state_nxt;
    logic                      vld_p1;
    logic [col*psum_bw-1:0]    out_data_p1;
    logic [addr_bw-1:0]        out_addr_p1;

    logic                      accept_p0;
    logic                      base_zero_p0;
    logic                      miss_p0;
    logic signed [psum_bw-1:0] sat_p0 [col];
    logic [col*psum_bw-1:0]    res_flat_p0;

    assign in_ready     = reset && (!vld_p1 || out_ready);
    assign accept_p0    = in_valid && in_ready;
    assign miss_p0      = !live_p1[in_addr];
    assign base_zero_p0 = in_first || miss_p0;

    // Stage p0: combinational read-modify of the addressed entry, so back-to-back
    // beats to one address see the previous edge's write without a bubble.
    always_comb begin
        logic signed [psum_bw-1:0] base;
        logic signed [psum_bw-1:0] lane_in;
        logic signed [psum_bw:0]   sum;
        base        = '0;
        lane_in     = '0;
        sum         = '0;
        res_flat_p0 = '0;
        for (int i = 0; i < col; i++) begin
            lane_in   = in_data[psum_bw*i +: psum_bw];
            base      = base_zero_p0 ? '0 : acc[in_addr][i];
            sum       = {base[psum_bw-1], base} + {lane_in[psum_bw-1], lane_in};
            sat_p0[i] = sat_psum(sum);
            res_flat_p0[psum_bw*i +: psum_bw] = relu_en ? relu(sat_p0[i]) : sat_p0[i];
        end
    end

    // Stage p1: accumulator write-back (data only, never reset).
    always_ff @(posedge clk) begin
        if (accept_p0) begin
            for (int i = 0; i < col; i++)
                acc[in_addr][i] <= sat_p0[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            live_p1 <= '0;
            err_p1  <= 1'b0;
        end else if (accept_p0) begin
            live_p1[in_addr] <= !in_last;
            if (!in_first && miss_p0)
                err_p1 <= 1'b1;
        end
    end

    // Output register FSM: state register.
    always_ff @(posedge clk) begin
        if (!reset)
            state_p1 <= EMPTY;
        else
            state_p1 <= state_nxt;
    end

    always_comb begin
        state_nxt = state_p1;
        case (state_p1)
            EMPTY: if (accept_p0 && in_last) state_nxt = FULL;
            FULL:  if (out_ready && !(accept_p0 && in_last)) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    always_comb begin
        vld_p1 = (state_p1 == FULL);
    end

    // A retiring beat is only accepted when the register is empty or draining,
    // so loading here never overwrites an unconsumed result.
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_data_p1 <= '0;
            out_addr_p1 <= '0;
        end else if (accept_p0 && in_last) begin
            out_data_p1 <= res_flat_p0;
            out_addr_p1 <= in_addr;
        end
    end

    assign out_valid = vld_p1;
    assign out_data  = out_data_p1;
    assign out_addr  = out_addr_p1;
    assign err       = err_p1;

endmodule

// File: tb/tb_sfu_acc_bank.sv
// Directed bench for sfu_acc_bank: reset, accumulation, ReLU, saturation,
// interleaving with backpressure, and the sticky error flag.
module tb_sfu_acc_bank;

    localparam int PW = 16;
    localparam int COL = 8;
    localparam int DEPTH = 16;
    localparam int AW = 4;
    localparam int W = PW * COL;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [AW-1:0] in_addr;
    logic          in_first;
    logic          in_last;
    logic          relu_en;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [AW-1:0] out_addr;
    logic          err;

    int tests = 0;
    int fails = 0;

    sfu_acc_bank #(.psum_bw(PW), .col(COL), .depth(DEPTH), .addr_bw(AW)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_addr(in_addr), .in_first(in_first), .in_last(in_last), .relu_en(relu_en),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_addr(out_addr), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] rep(input logic [PW-1:0] v);
        logic [W-1:0] r;
        for (int i = 0; i < COL; i++) r[PW*i +: PW] = v;
        return r;
    endfunction

    // Present one beat from a negedge; returns at the following negedge.
    task automatic drive(input logic [AW-1:0] a, input logic [W-1:0] d,
                         input logic f, input logic l, input logic r);
        in_valid = 1'b1;
        in_addr  = a;
        in_data  = d;
        in_first = f;
        in_last  = l;
        relu_en  = r;
        @(negedge clk);
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [W-1:0] lanes;
        reset     = 1'b0;
        in_valid  = 1'b1;
        in_data   = rep(16'h1234);
        in_addr   = 4'd3;
        in_first  = 1'b1;
        in_last   = 1'b1;
        relu_en   = 1'b0;
        out_ready = 1'b1;

        // Reset held 2 cycles with a beat offered.
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("rst_in_ready", W'(in_ready), W'(0));
            chk("rst_out_valid", W'(out_valid), W'(0));
            chk("rst_err", W'(err), W'(0));
            chk("rst_out_data", out_data, '0);
            chk("rst_out_addr", W'(out_addr), W'(0));
        end
        in_valid = 1'b0;
        reset    = 1'b1;
        #1;
        chk("post_rst_in_ready", W'(in_ready), W'(1));
        @(negedge clk);
        chk("post_rst_out_valid", W'(out_valid), W'(0));

        // Three-pass accumulation to addr 3: 5 - 2 + 10 = 13.
        drive(4'd3, rep(16'd5), 1, 0, 0);
        chk("acc_no_early_valid", W'(out_valid), W'(0));
        drive(4'd3, rep(16'hFFFE), 0, 0, 0);
        drive(4'd3, rep(16'd10), 0, 1, 1);
        chk("acc3_valid", W'(out_valid), W'(1));
        chk("acc3_data", out_data, rep(16'd13));
        chk("acc3_addr", W'(out_addr), W'(3));
        chk("acc3_err", W'(err), W'(0));
        idle();
        chk("acc3_drained", W'(out_valid), W'(0));

        // ReLU on a single-beat -7, then without ReLU back to back.
        drive(4'd5, rep(16'hFFF9), 1, 1, 1);
        chk("relu_on", out_data, rep(16'h0000));
        chk("relu_on_addr", W'(out_addr), W'(5));
        drive(4'd5, rep(16'hFFF9), 1, 1, 0);
        chk("relu_off", out_data, rep(16'hFFF9));
        chk("relu_off_valid", W'(out_valid), W'(1));

        // Distinct lane values pass through unchanged (lane packing).
        for (int i = 0; i < COL; i++) lanes[PW*i +: PW] = PW'(i * 100 + 1);
        drive(4'd6, lanes, 1, 1, 0);
        chk("lane_pack", out_data, lanes);

        // Saturation in both directions.
        drive(4'd2, rep(16'h7530), 1, 0, 0);
        drive(4'd2, rep(16'h7530), 0, 1, 0);
        chk("sat_pos", out_data, rep(16'h7FFF));
        drive(4'd2, rep(16'h8AD0), 1, 0, 0);
        drive(4'd2, rep(16'h8AD0), 0, 1, 0);
        chk("sat_neg", out_data, rep(16'h8000));
        idle();

        // Interleave addr 0 (1s) and addr 15 (2s), 4 passes each.
        for (int p = 0; p < 3; p++) begin
            drive(4'd0, rep(16'd1), p == 0, 0, 0);
            drive(4'd15, rep(16'd2), p == 0, 0, 0);
        end
        drive(4'd0, rep(16'd1), 0, 1, 0);
        chk("il_a0_data", out_data, rep(16'd4));
        chk("il_a0_addr", W'(out_addr), W'(0));
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_addr   = 4'd15;
        in_data   = rep(16'd2);
        in_first  = 1'b0;
        in_last   = 1'b1;
        #1;
        chk("bp_in_ready", W'(in_ready), W'(0));
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("bp_in_ready_hold", W'(in_ready), W'(0));
            chk("bp_valid_hold", W'(out_valid), W'(1));
            chk("bp_data_hold", out_data, rep(16'd4));
            chk("bp_addr_hold", W'(out_addr), W'(0));
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", W'(in_ready), W'(1));
        @(negedge clk);
        chk("il_a15_valid", W'(out_valid), W'(1));
        chk("il_a15_data", out_data, rep(16'd8));
        chk("il_a15_addr", W'(out_addr), W'(15));
        idle();
        chk("il_drained", W'(out_valid), W'(0));
        chk("il_err", W'(err), W'(0));

        // Error flag: fresh reset, then accumulate into a never-written entry.
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        drive(4'd7, rep(16'd9), 0, 0, 0);
        chk("err_set", W'(err), W'(1));
        drive(4'd7, rep(16'd0), 0, 1, 0);
        chk("err_entry9", out_data, rep(16'd9));
        chk("err_sticky1", W'(err), W'(1));
        drive(4'd7, rep(16'd1), 0, 0, 0);
        chk("err_sticky2", W'(err), W'(1));
        idle();
        reset = 1'b0;
        @(negedge clk);
        chk("err_clear", W'(err), W'(0));
        chk("err_rst_valid", W'(out_valid), W'(0));
        reset = 1'b1;

        // Reset mid-accumulation abandons the partial sum.
        drive(4'd4, rep(16'd5), 1, 0, 0);
        chk("mid_no_err", W'(err), W'(0));
        in_valid = 1'b0;
        reset    = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        drive(4'd4, rep(16'd3), 0, 1, 0);
        chk("mid_abandon", out_data, rep(16'd3));
        chk("mid_err", W'(err), W'(1));
        idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got 0 exp 1");
        $fatal(1, "timeout");
    end

endmodule
